seg_scan_signed_disp: RTL and testbench

- Parametrised multiplexed 7-segment scanner for the FND board. Accepts a signed two's-complement binary value through a load handshake.
- Converts the value to BCD sequentially (shift-add-3, one bit per clock) and drives DIGITS common-anode positions: one sign position plus DIGITS-1 BCD digits.
- Successor to the fixed-value sign+3-digit scanner. Top-level peripheral block, clocked by the 1 kHz board tick.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/fnd_decoder.sv | 24 ++
 rtl/seg_scan_signed_disp.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_signed_disp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and BCD helper for the signed 7-segment scanner.
package seg_pkg;

    localparam logic [7:0] SEG_MINUS   = 8'h02;
    localparam logic [7:0] SEG_BLANK   = 8'h00;
    // Wide enough for the largest DIGITS; users slice the low DIGITS bits.
    localparam logic [7:0] SEG_COM_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABS    = 2'd1,
        ST_CONV   = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    // Shift-add-3 correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/fnd_decoder.sv
// BCD digit to segment pattern {a,b,c,d,e,f,g,dp}, 1 = lit; non-decimal codes are blank.
module fnd_decoder (
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'h00;
        case (digit)
            4'd0: seg = 8'hFC;
            4'd1: seg = 8'h60;
            4'd2: seg = 8'hDA;
            4'd3: seg = 8'hF2;
            4'd4: seg = 8'h66;
            4'd5: seg = 8'hB6;
            4'd6: seg = 8'hBE;
            4'd7: seg = 8'hE0;
            4'd8: seg = 8'hFE;
            4'd9: seg = 8'hF6;
            default: seg = 8'h00;
        endcase
    end

endmodule

// File: rtl/seg_scan_signed_disp.sv
// Signed value -> sequential BCD conversion -> multiplexed sign + (DIGITS-1) digit scan.
// Define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digit positions.
module seg_scan_signed_disp
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk_1k,
    input  logic              resetn,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] seg_com,
    output logic [7:0]        seg_data
);

    localparam int BW = 4 * DIGITS;
    localparam int ND = DIGITS - 1;
    localparam int CW = $clog2(DIGITS);
    localparam int NW = $clog2(DATA_W + 1);

    conv_state_t state, state_n;

    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] mag;
    logic              sign_c;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic              ovf_acc;
    logic [NW-1:0]     bit_cnt;

    logic              disp_sign;
    logic [4*ND-1:0]   disp_bcd;

    logic [CW-1:0]     scan_pos;
    logic [ND-1:0]     lz;
    logic              lz_run;
    logic [3:0]        sel_nib;
    logic              sel_lz;
    logic [7:0]        dec_seg;
    logic [7:0]        pat;
    logic [DIGITS-1:0] com_n;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk_1k or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (load) state_n = ST_ABS;
            ST_ABS:    state_n = ST_CONV;
            ST_CONV:   if (bit_cnt == NW'(DATA_W - 1)) state_n = ST_COMMIT;
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = nib_adj(bcd[4*i +: 4]);
    end

    // A carry out of the guard nibble is sticky, so wide inputs on narrow displays still flag ovf.
    always_ff @(posedge clk_1k or negedge resetn) begin
        if (!resetn) begin
            val_q     <= '0;
            mag       <= '0;
            sign_c    <= 1'b0;
            bcd       <= '0;
            ovf_acc   <= 1'b0;
            bit_cnt   <= '0;
            disp_sign <= 1'b0;
            disp_bcd  <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (load) val_q <= value;
                ST_ABS: begin
                    sign_c  <= val_q[DATA_W-1];
                    mag     <= val_q[DATA_W-1] ? -val_q : val_q;
                    bcd     <= '0;
                    ovf_acc <= 1'b0;
                    bit_cnt <= '0;
                end
                ST_CONV: begin
                    bcd     <= {bcd_adj[BW-2:0], mag[DATA_W-1]};
                    mag     <= mag << 1;
                    ovf_acc <= ovf_acc | bcd_adj[BW-1];
                    bit_cnt <= bit_cnt + NW'(1);
                end
                ST_COMMIT: begin
                    disp_sign <= sign_c;
                    disp_bcd  <= bcd[4*ND-1:0];
                    ovf       <= ovf_acc | (bcd[BW-1 -: 4] != 4'd0);
                end
                default: ;
            endcase
        end
    end

    // lz[i]: nibble i and every more significant nibble are zero; nibble 0 is never blanked.
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
        for (int i = ND - 1; i >= 1; i--) begin
            lz_run = lz_run & (disp_bcd[4*i +: 4] == 4'd0);
            lz[i]  = lz_run;
        end
`endif
    end

    // Position p (1..ND) shows nibble ND-p, so the most significant digit sits leftmost.
    always_comb begin
        sel_nib = 4'd0;
        sel_lz  = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (scan_pos == CW'(ND - i)) begin
                sel_nib = disp_bcd[4*i +: 4];
                sel_lz  = lz[i];
            end
        end
    end

    fnd_decoder u_dec (
        .digit (sel_nib),
        .seg   (dec_seg)
    );

    always_comb begin
        if (scan_pos == '0)  pat = disp_sign ? SEG_MINUS : SEG_BLANK;
        else if (ovf)        pat = SEG_MINUS;
        else if (sel_lz)     pat = SEG_BLANK;
        else                 pat = dec_seg;
    end

    always_comb begin
        com_n = SEG_COM_OFF[DIGITS-1:0];
        for (int p = 0; p < DIGITS; p++)
            if (scan_pos == CW'(p)) com_n[DIGITS-1-p] = 1'b0;
    end

    always_ff @(posedge clk_1k or negedge resetn) begin
        if (!resetn) begin
            scan_pos <= '0;
            seg_com  <= SEG_COM_OFF[DIGITS-1:0];
            seg_data <= SEG_BLANK;
        end else begin
            scan_pos <= (scan_pos == CW'(DIGITS - 1)) ? '0 : scan_pos + CW'(1);
            seg_com  <= com_n;
            seg_data <= pat;
        end
    end

endmodule

// File: tb/tb_seg_scan_signed_disp.sv
// Scoreboard bench: expected display state is queued at load and checked once busy falls.
module tb_seg_scan_signed_disp;

    localparam int DIGITS = 4;
    localparam int DATA_W = 12;
    localparam int ND     = DIGITS - 1;

    typedef struct {
        logic                sign;
        logic                ovf;
        logic [ND-1:0][3:0]  dig;
    } exp_t;

    logic              clk_1k = 1'b0;
    logic              resetn = 1'b0;
    logic              load   = 1'b0;
    logic [DATA_W-1:0] value  = '0;
    logic              busy;
    logic              ovf;
    logic [DIGITS-1:0] seg_com;
    logic [7:0]        seg_data;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    seg_scan_signed_disp #(.DIGITS(DIGITS), .DATA_W(DATA_W)) dut (
        .clk_1k   (clk_1k),
        .resetn   (resetn),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .ovf      (ovf),
        .seg_com  (seg_com),
        .seg_data (seg_data)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] fnd_ref(input logic [3:0] d);
        case (d)
            4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;
            4'd3: return 8'hF2;  4'd4: return 8'h66;  4'd5: return 8'hB6;
            4'd6: return 8'hBE;  4'd7: return 8'hE0;  4'd8: return 8'hFE;
            4'd9: return 8'hF6;  default: return 8'h00;
        endcase
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int   m;
        int   lim;
        m   = (v < 0) ? -v : v;
        lim = 1;
        for (int k = 0; k < ND; k++) lim = lim * 10;
        e.sign = (v < 0);
        e.ovf  = (m > lim - 1);
        for (int k = 0; k < ND; k++) begin
            e.dig[k] = 4'(m % 10);
            m = m / 10;
        end
        return e;
    endfunction

    function automatic logic [7:0] pat_ref(input exp_t e, input int pos);
        int i;
        if (pos == 0) return e.sign ? 8'h02 : 8'h00;
        if (e.ovf) return 8'h02;
        i = ND - pos;
`ifdef SEG_SCAN_LZ_BLANK_EN
        begin
            logic lzb;
            lzb = (i > 0);
            for (int j = i; j < ND; j++) if (e.dig[j] != 4'd0) lzb = 1'b0;
            if (lzb) return 8'h00;
        end
`endif
        return fnd_ref(e.dig[i]);
    endfunction

    task automatic check_frame(input exp_t e, input string tag);
        int pos;
        for (int s = 0; s < DIGITS; s++) begin
            @(negedge clk_1k);
            pos = -1;
            for (int p = 0; p < DIGITS; p++) if (seg_com[DIGITS-1-p] == 1'b0) pos = p;
            chk({tag, "_onecold"}, $countones(~seg_com), 1);
            if (pos >= 0) chk($sformatf("%s_pos%0d", tag, pos), seg_data, pat_ref(e, pos));
        end
    endtask

    // pulse=1 also drives load during the busy window (cycles 3, 8 and the COMMIT cycle).
    task automatic do_load(input int v, input bit pulse, input string tag);
        int   cnt;
        exp_t e;
        @(negedge clk_1k);
        load  = 1'b1;
        value = DATA_W'(v);
        sb.push_back(model(v));
        @(negedge clk_1k);
        load = 1'b0;
        cnt  = 0;
        while (busy && cnt < 100) begin
            if (pulse && (cnt == 3 || cnt == 8 || cnt == DATA_W + 1)) begin
                load  = 1'b1;
                value = DATA_W'(12'h7FF);
            end
            @(negedge clk_1k);
            load = 1'b0;
            cnt++;
        end
        chk({tag, "_busy_len"}, cnt, DATA_W + 2);
        e = sb.pop_front();
        chk({tag, "_ovf"}, ovf, e.ovf);
        @(negedge clk_1k);
        chk({tag, "_no_requeue"}, busy, 1'b0);
        check_frame(e, tag);
    endtask

    initial begin
        exp_t       e;
        logic [3:0] com_exp;

        #12;
        chk("rst_com",  seg_com, 4'hF);
        chk("rst_data", seg_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf",  ovf, 1'b0);
        @(negedge clk_1k);
        resetn = 1'b1;

        e = model(0);
        for (int s = 0; s < DIGITS; s++) begin
            @(negedge clk_1k);
            com_exp = 4'b1000 >> s;
            com_exp = ~com_exp;
            chk($sformatf("init_com%0d", s), seg_com, com_exp);
            chk($sformatf("init_data%0d", s), seg_data, pat_ref(e, s));
        end

        do_load(-137,  1'b0, "m137");
        do_load(-512,  1'b0, "m512");
        do_load(1000,  1'b0, "p1000");
        do_load(999,   1'b0, "p999");
        do_load(-999,  1'b0, "m999");
        do_load(-2048, 1'b0, "mmin");
        do_load(2047,  1'b0, "pmax");
        do_load(7,     1'b0, "p7");
        do_load(40,    1'b0, "p40");
        do_load(0,     1'b0, "zero");
        do_load(-5,    1'b1, "ignore");
        for (int r = 0; r < 4; r++)
            do_load(int'($urandom_range(0, 3000)) - 1500, 1'b0, $sformatf("rnd%0d", r));

        // Abort a conversion with reset: outputs go idle at once, display back to +0.
        do_load(-321, 1'b0, "pre_abort");
        @(negedge clk_1k);
        load  = 1'b1;
        value = DATA_W'(-137);
        sb.push_back(model(-137));
        @(negedge clk_1k);
        load = 1'b0;
        repeat (5) @(negedge clk_1k);
        resetn = 1'b0;
        #1;
        chk("abort_com",  seg_com, 4'hF);
        chk("abort_data", seg_data, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ovf",  ovf, 1'b0);
        void'(sb.pop_front());
        @(negedge clk_1k);
        resetn = 1'b1;
        sb.push_back(model(0));
        e = sb.pop_front();
        check_frame(e, "abort_disp");
        chk("abort_idle", busy, 1'b0);

        do_load(88, 1'b0, "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
